// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined add/subtract unit for the ALU between operand fetch and result
//   writeback. The carry chain is cut into CHUNK-bit slices; stage k resolves
//   slice k, so latency is STAGES = WIDTH/CHUNK cycles at one op per cycle.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  operand handshake; in_ready is combinational
//   A, B, Cin, Op   operands; Op: 00 ADD, 01 SUB, 10 ADC, 11 SBB
//   out_valid/ready result handshake
//   Result          WIDTH-bit result
//   Cout            carry for ADD/ADC, borrow for SUB/SBB
//   Zero, Negative  Result == 0, Result MSB
//   Overflow        two's-complement signed overflow
module pipelined_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [1:0]       Op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Cout,
   output logic             Zero,
   output logic             Negative,
   output logic             Overflow
);

   localparam int STAGES = WIDTH / CHUNK;

   if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
   end

   // The whole pipe moves together; a stalled output freezes every stage.
   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Operand preparation: subtraction is A + ~B + 1, borrow-in flips the
   // raw carry so SBB is A + ~B + ~Cin.
   logic [WIDTH-1:0] b_prep;
   logic             c_first;
   assign b_prep  = Op[0] ? ~B : B;
   assign c_first = Op[1] ? (Cin ^ Op[0]) : Op[0];

   // Inter-stage registers. Entry k holds the state after stage k. Only the
   // unprocessed upper bits of a_q/b_q and the resolved lower bits of sum_q
   // are ever written or read; the last entry is replaced by the output regs.
   logic             v_q   [STAGES];
   logic             sub_q [STAGES];
   logic             c_q   [STAGES];
   logic [WIDTH-1:0] sum_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CHUNK;

      logic                v_i, sub_i, c_i;
      logic [WIDTH-LO-1:0] a_i, b_i;     // slices k..STAGES-1 still to do
      logic [LO+CHUNK-1:0] sum_n;        // slices 0..k after this stage
      logic [CHUNK:0]      s;

      assign s = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, c_i};

      if (k == 0) begin : g_src
         assign v_i   = in_valid;
         assign sub_i = Op[0];
         assign c_i   = c_first;
         assign a_i   = A;
         assign b_i   = b_prep;
         assign sum_n = s[CHUNK-1:0];
      end else begin : g_src
         assign v_i   = v_q[k-1];
         assign sub_i = sub_q[k-1];
         assign c_i   = c_q[k-1];
         assign a_i   = a_q[k-1][WIDTH-1:LO];
         assign b_i   = b_q[k-1][WIDTH-1:LO];
         assign sum_n = {s[CHUNK-1:0], sum_q[k-1][LO-1:0]};
      end

      if (k < STAGES-1) begin : g_mid
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_q[k]                        <= 1'b0;
               sub_q[k]                      <= 1'b0;
               c_q[k]                        <= 1'b0;
               sum_q[k][LO+CHUNK-1:0]        <= '0;
               a_q[k][WIDTH-1:LO+CHUNK]      <= '0;
               b_q[k][WIDTH-1:LO+CHUNK]      <= '0;
            end else if (advance) begin
               v_q[k]                        <= v_i;
               sub_q[k]                      <= sub_i;
               c_q[k]                        <= s[CHUNK];
               sum_q[k][LO+CHUNK-1:0]        <= sum_n;
               a_q[k][WIDTH-1:LO+CHUNK]      <= a_i[WIDTH-LO-1:CHUNK];
               b_q[k][WIDTH-1:LO+CHUNK]      <= b_i[WIDTH-LO-1:CHUNK];
            end
         end
      end else begin : g_last
         // Top slice still carries the operand MSBs, so the signed-overflow
         // test uses the prepared B exactly as the adder saw it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid <= 1'b0;
               Result    <= '0;
               Cout      <= 1'b0;
               Zero      <= 1'b0;
               Negative  <= 1'b0;
               Overflow  <= 1'b0;
            end else if (advance) begin
               out_valid <= v_i;
               Result    <= sum_n;
               Cout      <= s[CHUNK] ^ sub_i;
               Zero      <= (sum_n == '0);
               Negative  <= sum_n[WIDTH-1];
               Overflow  <= (a_i[CHUNK-1] == b_i[CHUNK-1]) &&
                            (sum_n[WIDTH-1] != a_i[CHUNK-1]);
            end
         end
      end
   end

endmodule
